uart_io_buffer: RTL

//  Buffered, parametrised UART I/O unit for the multicycle core; replaces the single-byte sdata/rdata_reg path.

---
 rtl/uart_io_buffer_pkg.sv | 35 +++
 rtl/uart_io_buffer_if.sv | 33 +++
 rtl/uart_io_buffer_sync_fifo.sv | 58 +++++
 rtl/uart_io_buffer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_io_buffer_pkg.sv
// uart_io_buffer_pkg
//   Shared types and helpers for the buffered UART I/O unit.
//   - tx_state_e / rx_state_e : 2-bit serial FSM state encodings
//   - BIT_CNT_W               : width of the data-bit counter (8 bits per frame)
//   - pack_byte()             : places one received byte into a big-endian word
package uart_io_buffer_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam int BIT_CNT_W = 3;

  // Byte idx (0 = first received) lands in bits [8*(nbytes-idx)-1 -: 8];
  // everything above 8*nbytes stays zero.
  function automatic logic [31:0] pack_byte(input logic [31:0] word,
                                            input logic [7:0]  b,
                                            input logic [1:0]  idx,
                                            input int unsigned nbytes);
    int unsigned sh;
    sh = 8 * (nbytes - 1 - 32'(idx));
    pack_byte = word | ({24'd0, b} << sh);
  endfunction

endpackage

// File: rtl/uart_io_buffer_if.sv
// uart_io_buffer_if
//   Core-side handshake bundle of the UART I/O unit.
//   Handshake rules:
//     TX: a byte transfers on every clock edge where out_valid && out_ready;
//         out_ready is high whenever the TX FIFO is not full.
//     RX: in_valid is high whenever a word is buffered, in_data shows the head
//         word; the head is consumed on every edge where in_req && in_valid.
//         in_req while in_valid is low has no effect.
//   Signals:
//     out_valid (core->uart) 1   byte offered
//     out_data  (core->uart) 8   byte to transmit
//     out_ready (uart->core) 1   byte can be accepted
//     in_req    (core->uart) 1   consume head word
//     in_data   (uart->core) 32  head word
//     in_valid  (uart->core) 1   head word present
interface uart_io_buffer_if;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        in_req;
  logic [31:0] in_data;
  logic        in_valid;

  modport master (
    output out_valid, out_data, in_req,
    input  out_ready, in_data, in_valid
  );

  modport slave (
    input  out_valid, out_data, in_req,
    output out_ready, in_data, in_valid
  );
endinterface

// File: rtl/uart_io_buffer_sync_fifo.sv
// uart_io_buffer_sync_fifo
//   Synchronous FIFO with 2**DEPTH_LOG2 entries of WIDTH bits.
//   Ports:
//     clk, rstn   clock, synchronous active-low reset (empties the FIFO)
//     push_i      write push_data_i; accepted if not full or popping this cycle
//     pop_i       drop head entry; ignored while empty
//     pop_data_o  head entry (combinational), zero while empty
//     full_o, empty_o, count_o  status; count = wr - rd with an extra MSB
module uart_io_buffer_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      pop_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2:0] wr_q;
  logic [DEPTH_LOG2:0] rd_q;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic                pop_en;
  logic                push_en;

  // Pointers carry one extra wrap bit so full and empty differ.
  assign count_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[DEPTH_LOG2] != rd_q[DEPTH_LOG2]) &&
                   (wr_q[DEPTH_LOG2-1:0] == rd_q[DEPTH_LOG2-1:0]);

  assign pop_en  = pop_i & ~empty_o;
  // A same-cycle pop frees the slot the push needs.
  assign push_en = push_i & (~full_o | pop_en);

  assign pop_data_o = empty_o ? '0 : mem_q[rd_q[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_en) wr_q <= wr_q + 1'b1;
      if (pop_en)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && push_en) mem_q[wr_q[DEPTH_LOG2-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/uart_io_buffer.sv
// uart_io_buffer
//   Buffered UART I/O unit: byte FIFO feeding a serial transmitter, serial
//   receiver packing 1/2/4 bytes (big-endian) into words pushed to a word FIFO.
//   Ports:
//     clk, rstn     clock, synchronous active-low reset
//     bus           core handshake bundle (slave side)
//     err_clr       clears ferr and overrun (a same-cycle set wins)
//     ferr          sticky framing error
//     overrun       sticky RX FIFO overrun (word dropped)
//     tx_count      TX FIFO occupancy
//     rx_count      RX FIFO occupancy
//     txd           serial out, idle high
//     rxd           serial in, asynchronous
//     dbg_tx_state  TX FSM state
//     dbg_rx_state  RX FSM state
module uart_io_buffer
  import uart_io_buffer_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 868,
  parameter int DEPTH_LOG2    = 4,
  parameter int RX_WORD_BYTES = 1
) (
  input  logic                clk,
  input  logic                rstn,
  uart_io_buffer_if.slave     bus,
  input  logic                err_clr,
  output logic                ferr,
  output logic                overrun,
  output logic [DEPTH_LOG2:0] tx_count,
  output logic [DEPTH_LOG2:0] rx_count,
  output logic                txd,
  input  logic                rxd,
  output tx_state_e           dbg_tx_state,
  output rx_state_e           dbg_rx_state
);

  localparam int              TMR_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [1:0]      LAST_BYTE = 2'(RX_WORD_BYTES - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = '1;

  // ---------------------------------------------------------------- TX path
  logic       tx_push;
  logic       tx_pop;
  logic       tx_full;
  logic       tx_empty;
  logic [7:0] tx_head;

  assign bus.out_ready = ~tx_full;
  assign tx_push       = bus.out_valid & ~tx_full;

  uart_io_buffer_sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_tx_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (tx_push),
    .push_data_i (bus.out_data),
    .pop_i       (tx_pop),
    .pop_data_o  (tx_head),
    .full_o      (tx_full),
    .empty_o     (tx_empty),
    .count_o     (tx_count)
  );

  tx_state_e            tx_state_q;
  logic [TMR_W-1:0]     tx_tmr_q;
  logic [BIT_CNT_W-1:0] tx_bit_q;
  logic [7:0]           tx_sh_q;
  logic                 tx_txd_q;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_tmr_q == TMR_LAST);
  // The last stop-bit cycle fetches the next byte directly, so back-to-back
  // frames have no idle cycle between them.
  assign tx_pop = ~tx_empty & ((tx_state_q == TX_IDLE) |
                               ((tx_state_q == TX_STOP) & tx_bit_end));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state_q <= TX_IDLE;
      tx_tmr_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_txd_q   <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_tmr_q <= '0;
          if (tx_pop) begin
            tx_sh_q    <= tx_head;
            tx_txd_q   <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_tmr_q   <= '0;
            tx_bit_q   <= '0;
            tx_txd_q   <= tx_sh_q[0];
            tx_state_q <= TX_DATA;
          end else begin
            tx_tmr_q <= tx_tmr_q + TMR_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_tmr_q <= '0;
            if (tx_bit_q == LAST_BIT) begin
              tx_txd_q   <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              // sh[1] is the next bit because the register shifts right here.
              tx_txd_q <= tx_sh_q[1];
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
              tx_bit_q <= tx_bit_q + 1'b1;
            end
          end else begin
            tx_tmr_q <= tx_tmr_q + TMR_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            tx_tmr_q <= '0;
            if (tx_pop) begin
              tx_sh_q    <= tx_head;
              tx_txd_q   <= 1'b0;
              tx_state_q <= TX_START;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_tmr_q <= tx_tmr_q + TMR_W'(1);
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign txd          = tx_txd_q;
  assign dbg_tx_state = tx_state_q;

  // ---------------------------------------------------------------- RX path
  logic rx_meta_q;
  logic rx_sync_q;
  logic rx_prev_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_state_e            rx_state_q;
  logic [TMR_W-1:0]     rx_tmr_q;
  logic [BIT_CNT_W-1:0] rx_bit_q;
  logic [7:0]           rx_sh_q;
  logic                 rx_stop_smp;
  logic                 rx_accept;
  logic                 rx_ferr_evt;

  // Stop-bit centre sample: high accepts the byte, low is a framing error.
  assign rx_stop_smp = (rx_state_q == RX_STOP) && (rx_tmr_q == TMR_LAST);
  assign rx_accept   = rx_stop_smp &  rx_sync_q;
  assign rx_ferr_evt = rx_stop_smp & ~rx_sync_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_state_q <= RX_IDLE;
      rx_tmr_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          rx_tmr_q <= '0;
          if (rx_prev_q && !rx_sync_q) rx_state_q <= RX_START;
        end
        RX_START: begin
          // Entered one cycle after the edge, so TMR_HALF lands mid start bit.
          if (rx_tmr_q == TMR_HALF) begin
            rx_tmr_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_tmr_q <= rx_tmr_q + TMR_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_tmr_q == TMR_LAST) begin
            rx_tmr_q <= '0;
            rx_sh_q  <= {rx_sync_q, rx_sh_q[7:1]};
            if (rx_bit_q == LAST_BIT) rx_state_q <= RX_STOP;
            else                      rx_bit_q   <= rx_bit_q + 1'b1;
          end else begin
            rx_tmr_q <= rx_tmr_q + TMR_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_stop_smp) begin
            rx_tmr_q   <= '0;
            rx_state_q <= RX_IDLE;
          end else begin
            rx_tmr_q <= rx_tmr_q + TMR_W'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign dbg_rx_state = rx_state_q;

  // ---------------------------------------------------------------- packer
  logic [1:0]  pk_idx_q;
  logic [31:0] pk_part_q;
  logic [31:0] pk_word_q;
  logic        pk_push_q;
  logic [31:0] pk_next;

  assign pk_next = pack_byte(pk_part_q, rx_sh_q, pk_idx_q, RX_WORD_BYTES);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pk_idx_q  <= '0;
      pk_part_q <= '0;
      pk_word_q <= '0;
      pk_push_q <= 1'b0;
    end else begin
      pk_push_q <= 1'b0;
      if (rx_accept) begin
        if (pk_idx_q == LAST_BYTE) begin
          pk_word_q <= pk_next;
          pk_push_q <= 1'b1;
          pk_part_q <= '0;
          pk_idx_q  <= '0;
        end else begin
          pk_part_q <= pk_next;
          pk_idx_q  <= pk_idx_q + 1'b1;
        end
      end
    end
  end

  logic rx_full;
  logic rx_empty;
  logic rx_pop_en;
  logic ovr_evt;

  uart_io_buffer_sync_fifo #(
    .WIDTH      (32),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rx_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (pk_push_q),
    .push_data_i (pk_word_q),
    .pop_i       (bus.in_req),
    .pop_data_o  (bus.in_data),
    .full_o      (rx_full),
    .empty_o     (rx_empty),
    .count_o     (rx_count)
  );

  assign bus.in_valid = ~rx_empty;
  assign rx_pop_en    = bus.in_req & ~rx_empty;
  // The FIFO drops the word in exactly this case.
  assign ovr_evt      = pk_push_q & rx_full & ~rx_pop_en;

  // ---------------------------------------------------------------- flags
  logic ferr_q;
  logic ovr_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (rx_ferr_evt)  ferr_q <= 1'b1;
      else if (err_clr) ferr_q <= 1'b0;
      if (ovr_evt)      ovr_q  <= 1'b1;
      else if (err_clr) ovr_q  <= 1'b0;
    end
  end

  assign ferr    = ferr_q;
  assign overrun = ovr_q;

endmodule
